// File: rtl/fu_cdb_pkg.sv
// fu_cdb_pkg
// Shared types and widths for the FU-to-CDB writeback arbiter.
// Contents:
//   - default channel, port and depth counts
//   - PRF tag, ROB index, branch mask and value widths
//   - cdb_entry_t: one buffered writeback result
//   - resolve_entry(): applies a branch resolution event to one entry
package fu_cdb_pkg;

    localparam int N_FU_DEF  = 5;
    localparam int N_CDB_DEF = 2;
    localparam int DEPTH_DEF = 2;

    localparam int BR_MASK_W = 5;
    localparam int PRF_IDX_W = 6;
    localparam int ROB_IDX_W = 5;
    localparam int ROB_W     = ROB_IDX_W + 1;
    localparam int VALUE_W   = 64;

    // Physical register 0 is hardwired; idle CDB ports present it as their tag.
    localparam logic [PRF_IDX_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic                 live;
        logic                 wr_en;
        logic [PRF_IDX_W-1:0] tag;
        logic [VALUE_W-1:0]   value;
        logic [ROB_W-1:0]     rob_idx;
        logic [BR_MASK_W-1:0] br_mask;
    } cdb_entry_t;

    // Recovery kills any entry that depends on the resolved branch; a correct
    // prediction just drops that branch from the mask. Recovery takes precedence
    // if both ever arrive together.
    function automatic cdb_entry_t resolve_entry(
        input cdb_entry_t           e,
        input logic                 recovery,
        input logic                 pred_correct,
        input logic [BR_MASK_W-1:0] tag_fix
    );
        cdb_entry_t r;
        r = e;
        if (recovery) begin
            if ((e.br_mask & tag_fix) != '0) begin
                r.live = 1'b0;
            end
        end else if (pred_correct) begin
            r.br_mask = e.br_mask & ~tag_fix;
        end
        return r;
    endfunction

endpackage

// File: rtl/fu_cdb_arbiter_if.sv
// fu_cdb_arbiter_if
// Bundles the FU request channels, the ROB branch-resolution inputs and the
// CDB broadcast ports of fu_cdb_arbiter.
// Modports:
//   master : the FU / ROB side (drives requests and resolution, sees rdy and CDB)
//   slave  : the arbiter (accepts requests, drives rdy and CDB)
interface fu_cdb_arbiter_if
    import fu_cdb_pkg::*;
#(
    parameter int N_FU  = N_FU_DEF,
    parameter int N_CDB = N_CDB_DEF
) ();

    logic [N_FU-1:0]            fu_vld_i;
    logic [N_FU-1:0]            fu_wr_en_i;
    logic [N_FU*PRF_IDX_W-1:0]  fu_tag_i;
    logic [N_FU*VALUE_W-1:0]    fu_value_i;
    logic [N_FU*ROB_W-1:0]      fu_rob_idx_i;
    logic [N_FU*BR_MASK_W-1:0]  fu_br_mask_i;
    logic [N_FU-1:0]            fu_rdy_o;

    logic                       rob_br_recovery_i;
    logic                       rob_br_pred_correct_i;
    logic [BR_MASK_W-1:0]       rob_br_tag_fix_i;

    logic [N_CDB-1:0]           cdb_vld_o;
    logic [N_CDB-1:0]           cdb_wr_en_o;
    logic [N_CDB*PRF_IDX_W-1:0] cdb_tag_o;
    logic [N_CDB*VALUE_W-1:0]   cdb_value_o;
    logic [N_CDB*ROB_W-1:0]     cdb_rob_idx_o;

    modport master (
        output fu_vld_i, fu_wr_en_i, fu_tag_i, fu_value_i, fu_rob_idx_i, fu_br_mask_i,
        output rob_br_recovery_i, rob_br_pred_correct_i, rob_br_tag_fix_i,
        input  fu_rdy_o,
        input  cdb_vld_o, cdb_wr_en_o, cdb_tag_o, cdb_value_o, cdb_rob_idx_o
    );

    modport slave (
        input  fu_vld_i, fu_wr_en_i, fu_tag_i, fu_value_i, fu_rob_idx_i, fu_br_mask_i,
        input  rob_br_recovery_i, rob_br_pred_correct_i, rob_br_tag_fix_i,
        output fu_rdy_o,
        output cdb_vld_o, cdb_wr_en_o, cdb_tag_o, cdb_value_o, cdb_rob_idx_o
    );

endinterface

// File: rtl/fu_wb_fifo.sv
// fu_wb_fifo
// Per-channel writeback buffer. Every stored entry sees branch resolution each
// cycle: recovery clears the live bit of dependent entries, a correct
// prediction clears the resolved bit from the mask. Incoming entries get the
// same treatment on their way in.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push          write push_entry at the tail (ignored when full)
//   push_entry    entry to enqueue (live bit set by the caller)
//   pop           drop the head (ignored when empty)
//   recovery, pred_correct, tag_fix   branch resolution event
//   head          entry at the head (only meaningful when count != 0)
//   count         number of stored entries, 0..DEPTH
module fu_wb_fifo
    import fu_cdb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  cdb_entry_t           push_entry,
    input  logic                 pop,
    input  logic                 recovery,
    input  logic                 pred_correct,
    input  logic [BR_MASK_W-1:0] tag_fix,
    output cdb_entry_t           head,
    output logic [CNT_W-1:0]     count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cdb_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_push = push & (count < CNT_W'(DEPTH));
    assign do_pop  = pop & (count != '0);
    assign head    = mem[head_ptr];

    // Storage, pointers and occupancy. The resolution update touches every
    // slot; the tail write afterwards is safe because a push only lands in a
    // free slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= resolve_entry(mem[i], recovery, pred_correct, tag_fix);
            end
            if (do_push) begin
                mem[tail_ptr] <= resolve_entry(push_entry, recovery, pred_correct, tag_fix);
                tail_ptr      <= bump(tail_ptr);
            end
            if (do_pop) begin
                head_ptr <= bump(head_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fu_cdb_arbiter.sv
// fu_cdb_arbiter
// Writeback arbiter between N_FU execution-unit channels and N_CDB common data
// bus ports. Each channel is buffered in a fu_wb_fifo. Channel 0 (branch unit)
// owns port 0 whenever it has a live head; the remaining ports are handed to
// channels 1..N_FU-1 round-robin starting at rr_ptr.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   bus       fu_cdb_arbiter_if.slave: FU requests/rdy, ROB branch
//             resolution, CDB broadcast outputs
module fu_cdb_arbiter
    import fu_cdb_pkg::*;
#(
    parameter int N_FU  = N_FU_DEF,
    parameter int N_CDB = N_CDB_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    fu_cdb_arbiter_if.slave   bus
);

    localparam int CH_W  = (N_FU > 1) ? $clog2(N_FU) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    cdb_entry_t       push_entry [N_FU];
    cdb_entry_t       head       [N_FU];
    logic [CNT_W-1:0] count      [N_FU];
    logic [N_FU-1:0]  push;
    logic [N_FU-1:0]  pop;
    logic [N_FU-1:0]  grant;
    logic [N_FU-1:0]  eligible;
    logic [N_FU-1:0]  free_pop;
    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  rr_next;
    logic [N_CDB-1:0] port_vld;
    logic [CH_W-1:0]  port_ch [N_CDB];

    for (genvar g = 0; g < N_FU; g++) begin : g_chan
        assign bus.fu_rdy_o[g] = (count[g] < CNT_W'(DEPTH));
        assign push[g]         = bus.fu_vld_i[g] & bus.fu_rdy_o[g];
        assign pop[g]          = grant[g] | free_pop[g];

        assign push_entry[g] = '{
            live:    1'b1,
            wr_en:   bus.fu_wr_en_i[g],
            tag:     bus.fu_tag_i[g*PRF_IDX_W +: PRF_IDX_W],
            value:   bus.fu_value_i[g*VALUE_W +: VALUE_W],
            rob_idx: bus.fu_rob_idx_i[g*ROB_W +: ROB_W],
            br_mask: bus.fu_br_mask_i[g*BR_MASK_W +: BR_MASK_W]
        };

        fu_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk          (clk),
            .rst          (rst),
            .push         (push[g]),
            .push_entry   (push_entry[g]),
            .pop          (pop[g]),
            .recovery     (bus.rob_br_recovery_i),
            .pred_correct (bus.rob_br_pred_correct_i),
            .tag_fix      (bus.rob_br_tag_fix_i),
            .head         (head[g]),
            .count        (count[g])
        );
    end

    // Head classification. Nothing is granted while recovery is high: the CDB
    // must stay quiet, and granting would pop a result nobody saw. A head that
    // depends on the resolving branch is also excluded outright. Dead heads
    // (already squashed) are dropped without a port, but only from their stored
    // live bit, so a head squashed this cycle drains on the following one.
    always_comb begin
        eligible = '0;
        free_pop = '0;
        for (int c = 0; c < N_FU; c++) begin
            if (count[c] != '0) begin
                eligible[c] = head[c].live & ~bus.rob_br_recovery_i
                            & ~(|(head[c].br_mask & bus.rob_br_tag_fix_i) & bus.rob_br_recovery_i);
                free_pop[c] = ~head[c].live;
            end
        end
    end

    // Port allocation: channel 0 first, then channels 1..N_FU-1 scanned upward
    // from rr_ptr with wrap, filling the lowest free port each time. rr_next
    // points just past the last non-zero channel that won a port.
    always_comb begin
        int              n_used;
        int              ch;
        logic            any_rr;
        logic [CH_W-1:0] last_ch;

        grant    = '0;
        port_vld = '0;
        for (int p = 0; p < N_CDB; p++) begin
            port_ch[p] = '0;
        end
        n_used  = 0;
        ch      = 0;
        any_rr  = 1'b0;
        last_ch = rr_ptr;

        if (eligible[0]) begin
            grant[0]    = 1'b1;
            port_vld[0] = 1'b1;
            n_used      = 1;
        end

        for (int k = 0; k < N_FU - 1; k++) begin
            ch = int'(rr_ptr) + k;
            if (ch > N_FU - 1) begin
                ch = ch - (N_FU - 1);
            end
            for (int c = 1; c < N_FU; c++) begin
                if (c == ch && eligible[c] && n_used < N_CDB) begin
                    grant[c] = 1'b1;
                    for (int p = 0; p < N_CDB; p++) begin
                        if (p == n_used) begin
                            port_vld[p] = 1'b1;
                            port_ch[p]  = CH_W'(c);
                        end
                    end
                    n_used  = n_used + 1;
                    any_rr  = 1'b1;
                    last_ch = CH_W'(c);
                end
            end
        end

        rr_next = rr_ptr;
        if (any_rr) begin
            rr_next = (last_ch == CH_W'(N_FU - 1)) ? CH_W'(1) : last_ch + CH_W'(1);
        end
    end

    // Round-robin pointer; starts at channel 1 since channel 0 is not rotated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= CH_W'(1);
        end else begin
            rr_ptr <= rr_next;
        end
    end

    // Port muxes. Idle ports drive all-zero fields with the zero-register tag.
    for (genvar p = 0; p < N_CDB; p++) begin : g_port
        assign bus.cdb_vld_o[p]   = port_vld[p];
        assign bus.cdb_wr_en_o[p] = port_vld[p] & head[port_ch[p]].wr_en;
        assign bus.cdb_tag_o[p*PRF_IDX_W +: PRF_IDX_W] =
            port_vld[p] ? head[port_ch[p]].tag : ZERO_REG;
        assign bus.cdb_value_o[p*VALUE_W +: VALUE_W] =
            port_vld[p] ? head[port_ch[p]].value : '0;
        assign bus.cdb_rob_idx_o[p*ROB_W +: ROB_W] =
            port_vld[p] ? head[port_ch[p]].rob_idx : '0;
    end

endmodule

// File: doc/fu_cdb_arbiter.md
# fu_cdb_arbiter

Parametrised writeback arbiter between the execution units and the common data bus. It replaces fixed-priority single-CDB selection with N_FU buffered request channels and N_CDB broadcast ports. Channel 0 (branch) has fixed top priority and the other channels share the remaining ports round-robin. Buffered results are squashed on branch recovery, and their masks are updated on a correct prediction. It sits between the FU instances and the PRF write ports, ROB completion and RS wakeup.

## Interface
- N_FU, 5: request channels; channel 0 = branch unit.
- N_CDB, 2: broadcast ports per cycle, 1..N_FU.
- DEPTH, 2: entries per channel FIFO, ≥1.
- BR_MASK_W, `BR_MASK_W`: branch mask width.
- PRF_IDX_W, `PRF_IDX_W`; ROB_W, `ROB_IDX_W`+1.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- fu_vld_i  in  N_FU  result offered on channel.
- fu_wr_en_i  in  N_FU  result writes PRF/wakes RS (0 = ROB-only completion, e.g. store).
- fu_tag_i  in  N_FU*PRF_IDX_W  destination tag.
- fu_value_i  in  N_FU*64  result value.
- fu_rob_idx_i  in  N_FU*ROB_W  ROB index.
- fu_br_mask_i  in  N_FU*BR_MASK_W  branch mask.
- fu_rdy_o  out  N_FU  channel can accept (FIFO not full).
- rob_br_recovery_i, rob_br_pred_correct_i  in  1  branch resolution events.
- rob_br_tag_fix_i  in  BR_MASK_W  one-hot resolved branch.
- cdb_vld_o  out  N_CDB  port carries a result this cycle.
- cdb_wr_en_o  out  N_CDB  PRF write / tag broadcast enable.
- cdb_tag_o  out  N_CDB*PRF_IDX_W.
- cdb_value_o  out  N_CDB*64.
- cdb_rob_idx_o  out  N_CDB*ROB_W.

## Operation
- Enqueue: channel i writes its FIFO tail at clk edge when fu_vld_i[i] & fu_rdy_o[i]. fu_vld_i with fu_rdy_o low is ignored; the FU must hold the result (stall).
- fu_rdy_o[i] = count[i] < DEPTH. A full FIFO does not accept, even on a same-cycle pop; there is no comb path from grant to rdy.
- Entry fields: live bit, wr_en, tag, value, rob_idx, br_mask.
- Grant, combinational over FIFO heads each cycle:
  - Channel 0 live head always takes port 0.
  - Remaining ports go to live heads of channels 1..N_FU-1, scanning upward from rr_ptr with wrap.
  - Ports are filled lowest-index first; unused ports have cdb_vld_o=0 and zeroed fields (tag = `ZERO_REG).
- rr_ptr update: the channel after the last granted non-zero channel, mod N_FU-1 over 1..N_FU-1. It is unchanged if no non-zero channel is granted.
- Dequeue: each granted head pops at the edge. A non-live head pops free, without a port, at most one per channel per cycle.
- Squash, rob_br_recovery_i:
  - Every stored entry with br_mask & rob_br_tag_fix_i ≠ 0 has its live bit cleared at the edge.
  - A matching incoming entry is enqueued non-live.
  - Matching heads are masked off the CDB in the same cycle.
  - Outputs: cdb_vld_o, cdb_wr_en_o forced 0 while recovery is high.
- Correct prediction, rob_br_pred_correct_i: the rob_br_tag_fix_i bit is cleared in all stored masks and in incoming masks at enqueue.
- Recovery and pred_correct are never asserted together; if both occur, recovery wins.

## Timing
- Latency: result enqueued at edge k → on cdb_*_o in cycle k+1 at the earliest. Sustained one result per channel per cycle if granted every cycle.
- After reset:
  - All FIFOs are empty, rr_ptr=1, fu_rdy_o all 1.
  - cdb_vld_o, cdb_wr_en_o = 0.
  - cdb_tag_o = `ZERO_REG; value and rob_idx are 0.
- Reset asserted mid-operation empties all FIFOs immediately (asynchronous); no outputs glitch high.
- Pointer wrap: DEPTH not a power of two is supported; head/tail wrap at DEPTH-1, and count is $clog2(DEPTH+1) bits.
- A squashed head is popped in the cycle after recovery.

## Structure
- Shared package fu_cdb_pkg: typedef cdb_entry_t {live, wr_en, tag, value, rob_idx, br_mask}, plus N_FU/N_CDB defaults.
- Sub-module fu_wb_fifo: one per channel via generate. It holds per-entry squash/mask-clear logic and exposes head, count and pop.
- Top level: grant scan, rr_ptr register, port muxes.

## Test plan
- Reset, then ch2 offers tag 7, value 0x55 at cycle 1 → cycle 2: cdb_vld_o[0]=1, tag 7, value 0x55, fu_rdy_o=all 1.
- Ch0, ch1, ch3 valid same cycle, N_CDB=2 → port0=ch0, port1=ch1; next cycle port0=ch3, and rr_ptr skips to 4.
- Ch1 offered 3 times with no grants (ch0 busy, N_CDB=1) → fu_rdy_o[1]=0 after 2 enqueues, and the third beat is held until a pop.
- Ch1 entry mask 5'b00100, recovery with fix 5'b00100 → entry is never broadcast, and the FIFO drains in 1 cycle.
- pred_correct with fix 5'b00100, then recovery with fix 5'b00100 → the entry is broadcast normally.
- rst pulsed while FIFOs are full → all cdb_vld_o=0 immediately, and fu_rdy_o all 1 after release.
